dyt_rf_wb_arbiter: RTL
======================

Name: dyt_rf_wb_arbiter

Overview:
Shares the single write port of the 16-entry register file between two writeback sources: requester 0 (ALU) and requester 1 (LSU load return). Each source uses a valid/ready handshake. The block arbitrates round-robin and registers the granted write into an output stage that drives the register file w_en/w_addr/w_data. It also reports pending-write hits for both read addresses so the decode stage can stall on RAW hazards.

Parameters:
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 4, register address width (16 registers, x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
hold  in  1  freeze arbitration (debug/flush); no new grants while high
req0_valid  in  1  ALU write request
req0_ready  out  1  ALU request accepted this cycle
req0_addr  in  ADDR_WIDTH  ALU destination register
req0_data  in  DATA_WIDTH  ALU result
req1_valid  in  1  LSU write request
req1_ready  out  1  LSU request accepted this cycle
req1_addr  in  ADDR_WIDTH  LSU destination register
req1_data  in  DATA_WIDTH  LSU load data
w_en  out  1  register file write enable
w_addr  out  ADDR_WIDTH  register file write address
w_data  out  DATA_WIDTH  register file write data
r_a_addr  in  ADDR_WIDTH  decode read port A address
r_b_addr  in  ADDR_WIDTH  decode read port B address
hit_a  out  1  write to r_a_addr pending (requested or in output stage)
hit_b  out  1  write to r_b_addr pending

Behaviour:
- Reset (rst low, async): w_en=0, w_addr=0, w_data=0, RR pointer=0 (requester 0 preferred); req*_ready=0 while in reset.
- Handshake: transfer when reqN_valid && reqN_ready. Requester holds valid/addr/data stable until transfer. Ready may depend combinationally on valid; valid must not depend on ready.
- Arbitration (combinational, each cycle, hold=0):
  - only one valid -> grant it.
  - both valid -> grant requester indicated by RR pointer.
  - none valid -> no grant.
  - hold=1 -> no grants, both ready=0.
- RR pointer: on any grant to i, pointer <= 1-i. Unchanged with no grant.
- Output stage: 1-cycle latency. On grant at edge k, w_en/w_addr/w_data present the write during cycle k+1. The register file writes at end of k+1. With no grant, w_en=0; w_addr/w_data hold last values.
- Output stage always drains (register file never stalls), so back-to-back grants every cycle are allowed: throughput 1 write/cycle.
- x0 writes: the request is granted (ready=1, handshake completes, pointer advances), but w_en stays 0 for that slot.
- Same-address collision (both valid, same nonzero addr): resolved purely by RR order. Program ordering is the upstream's responsibility. No merging.
- hit_a = (r_a_addr!=0) && ((req0_valid && req0_addr==r_a_addr) || (req1_valid && req1_addr==r_a_addr) || (w_en && w_addr==r_a_addr)). hit_b is identical with r_b_addr. Purely combinational; hits are independent of hold.
- hold asserted mid-stream: a write already in the output stage still completes the next cycle; pending requests wait.
- Reset mid-operation: an in-flight output-stage write is discarded (w_en forced 0 immediately).

Decomposition:
- Package dyt_rf_pkg: DATA_WIDTH, ADDR_WIDTH, NUM_WORDS=2**ADDR_WIDTH, REQ_ALU=0, REQ_LSU=1, ZERO_REG=0.
- Sub-module dyt_rr_arbiter2: 2-input round-robin arbiter. Inputs are req[1:0] and hold; outputs are gnt[1:0] (one-hot or zero), with the pointer register internal. The top level instantiates it and holds the output stage and hit logic.

Test Plan:
- Reset release, both idle -> w_en=0, w_addr=0, w_data=0, ready0=ready1=0, hit_a=hit_b=0.
- Only req0 valid, addr=5, data=0xDEADBEEF -> ready0=1 same cycle; next cycle w_en=1, w_addr=5, w_data=0xDEADBEEF; then w_en=0.
- Both valid continuously (req0 addr3/0x11, req1 addr4/0x22, then new data each accept) -> grants alternate 0,1,0,1. w_en stays high every cycle; w_addr sequence is 3,4,3,4.
- req1 valid, addr=0, data=0xFFFFFFFF -> ready1=1, pointer advances, w_en stays 0 next cycle. With r_a_addr=0, hit_a=0.
- hold=1 with both valid -> ready0=ready1=0 and w_en=0 from the following cycle. Release hold with pointer=1 -> req1 granted first.
- req0 valid, addr=7, r_a_addr=7, r_b_addr=8 -> hit_a=1, hit_b=0 while requesting and during the w_en cycle; hit_a=0 the cycle after.

Source files
------------

// File: rtl/dyt_rf_pkg.sv
// Shared definitions for the register-file writeback path.
//   DATA_WIDTH / ADDR_WIDTH : default write data and register address widths
//   NUM_WORDS               : number of architectural registers
//   REQ_ALU / REQ_LSU       : requester indices into request/grant vectors
//   ZERO_REG                : hardwired-zero register index (writes discarded)
package dyt_rf_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LSU    = 1;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/dyt_rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   hold     : suppress all grants while high
//   req[1:0] : request vector (REQ_ALU / REQ_LSU)
//   gnt[1:0] : grant vector, one-hot or zero, combinational from req
// The priority pointer flips to the other requester after every grant.
module dyt_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import dyt_rf_pkg::*;

    // ptr_reg = 0 prefers the ALU, 1 prefers the LSU
    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        // No grants while reset is asserted so ready stays low in reset.
        if (rst && !hold) begin
            if (req[REQ_ALU] && req[REQ_LSU]) begin
                if (ptr_reg) begin
                    gnt[REQ_LSU] = 1'b1;
                end else begin
                    gnt[REQ_ALU] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
        if (gnt[REQ_ALU]) begin
            ptr_next = 1'b1;
        end else if (gnt[REQ_LSU]) begin
            ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/dyt_rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between the ALU (requester 0)
// and the LSU load return (requester 1) with round-robin arbitration and a
// one-cycle registered output stage. Also flags pending writes to the two
// decode read addresses for RAW hazard stalls.
//   clk, rst                          : clock, asynchronous active-low reset
//   hold                              : freeze arbitration
//   req0_valid/ready/addr/data        : ALU writeback handshake
//   req1_valid/ready/addr/data        : LSU writeback handshake
//   w_en, w_addr, w_data              : register file write port
//   r_a_addr, r_b_addr                : decode read addresses
//   hit_a, hit_b                      : pending write to the read address
module dyt_rf_wb_arbiter #(
    parameter int DATA_WIDTH = dyt_rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dyt_rf_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_a_addr,
    input  logic [ADDR_WIDTH-1:0] r_b_addr,
    output logic                  hit_a,
    output logic                  hit_b
);
    import dyt_rf_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [1:0]            req_vec;
    logic [1:0]            gnt_vec;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  w_en_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;

    assign req_vec[REQ_ALU] = req0_valid;
    assign req_vec[REQ_LSU] = req1_valid;

    dyt_rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .req  (req_vec),
        .gnt  (gnt_vec)
    );

    assign req0_ready = gnt_vec[REQ_ALU];
    assign req1_ready = gnt_vec[REQ_LSU];
    assign gnt_any    = |gnt_vec;
    assign gnt_addr   = gnt_vec[REQ_LSU] ? req1_addr : req0_addr;
    assign gnt_data   = gnt_vec[REQ_LSU] ? req1_data : req0_data;

    // Output stage. An x0 write still consumes its slot (handshake done,
    // pointer advanced) but never raises w_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en_reg   <= 1'b0;
            w_addr_reg <= '0;
            w_data_reg <= '0;
        end else begin
            w_en_reg <= gnt_any && (gnt_addr != ZERO_ADDR);
            if (gnt_any) begin
                w_addr_reg <= gnt_addr;
                w_data_reg <= gnt_data;
            end
        end
    end

    assign w_en   = w_en_reg;
    assign w_addr = w_addr_reg;
    assign w_data = w_data_reg;

    // Hazard detection, one instance per decode read port.
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [1:0]            hit_vec;

    assign rd_addr[0] = r_a_addr;
    assign rd_addr[1] = r_b_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit_vec[gi] = (rd_addr[gi] != ZERO_ADDR) &&
                                 ((req0_valid && (req0_addr  == rd_addr[gi])) ||
                                  (req1_valid && (req1_addr  == rd_addr[gi])) ||
                                  (w_en_reg   && (w_addr_reg == rd_addr[gi])));
        end
    endgenerate

    assign hit_a = hit_vec[0];
    assign hit_b = hit_vec[1];
endmodule
